// File: rtl/pipeline_defs.sv
// pipeline_defs: encodings shared by the RV32I pipeline control and hazard logic.
package pipeline_defs;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_GE = 2'b11;

    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic [1:0] br_type;
        logic       jump;
        logic       jalr;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_t;

    // Shared by R and I formats; unsupported funct3 values fall back to add.
    function automatic logic [2:0] alu_op(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction
endpackage

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: operand forwarding selects, load-use stall and redirect flushes.
module pipeline_hazard_unit
    import pipeline_defs::*;
(
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE
);
    logic lw_stall;

    assign ForwardAE = (RegWriteM && RdM != 5'd0 && RdM == Rs1E) ? FWD_M :
                       (RegWriteW && RdW != 5'd0 && RdW == Rs1E) ? FWD_W : FWD_RD;
    assign ForwardBE = (RegWriteM && RdM != 5'd0 && RdM == Rs2E) ? FWD_M :
                       (RegWriteW && RdW != 5'd0 && RdW == Rs2E) ? FWD_W : FWD_RD;

    assign lw_stall = ResultSrcE == RES_MEM && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    // A redirect discards the stalled instruction anyway, so it must not hold the PC.
    assign StallF = lw_stall & ~PCSrcE;
    assign StallD = lw_stall & ~PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = lw_stall | PCSrcE;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: RV32I decode, D/E/M/W control registers and branch resolution
// for the 5-stage datapath; forwarding and stall logic live in pipeline_hazard_unit.
module pipeline_controller
    import pipeline_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       ZeroE,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    output logic [2:0] ImmSrcD,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       jalrE,
    output logic       PCSrcE,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       clear
);
    ctrl_t      ctrl_d, ctrl_e;
    logic       reg_write_m, mem_write_m, reg_write_w, taken_e;
    logic [1:0] result_src_m, result_src_w;
    logic       unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        ctrl_d  = '0;
        ImmSrcD = IMM_I;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_control = alu_op(funct3, funct7[5]);
            end
            OP_I: begin
                ctrl_d.reg_write   = 1'b1;
                ctrl_d.alu_src     = 1'b1;
                ctrl_d.alu_control = alu_op(funct3, 1'b0);
            end
            OP_LW: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_MEM;
                ctrl_d.alu_src    = 1'b1;
            end
            OP_SW: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ImmSrcD          = IMM_S;
            end
            OP_B: begin
                // Only beq/bne/blt/bge exist here: funct3[1] marks the unsigned variants.
                ctrl_d.branch      = ~funct3[1];
                ctrl_d.br_type     = funct3[2] ? (funct3[0] ? BR_GE : BR_LT) : (funct3[0] ? BR_NE : BR_EQ);
                ctrl_d.alu_control = funct3[2] ? ALU_SLT : ALU_SUB;
                ImmSrcD            = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.jump       = 1'b1;
                ImmSrcD           = IMM_J;
            end
            OP_JALR: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_PC4;
                ctrl_d.jump       = 1'b1;
                ctrl_d.jalr       = 1'b1;
                ctrl_d.alu_src    = 1'b1;
            end
            OP_LUI: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = RES_IMM;
                ImmSrcD           = IMM_U;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e       <= '0;
            reg_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            mem_write_m  <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= RES_ALU;
        end else begin
            ctrl_e       <= FlushE ? '0 : ctrl_d;
            reg_write_m  <= ctrl_e.reg_write;
            result_src_m <= ctrl_e.result_src;
            mem_write_m  <= ctrl_e.mem_write;
            reg_write_w  <= reg_write_m;
            result_src_w <= result_src_m;
        end
    end

    // eq/ge take on zero, ne/lt take on non-zero.
    assign taken_e     = ZeroE ^ (ctrl_e.br_type == BR_NE || ctrl_e.br_type == BR_LT);
    assign PCSrcE      = ctrl_e.jump | (ctrl_e.branch & taken_e);
    assign ALUSrcE     = ctrl_e.alu_src;
    assign ALUControlE = ctrl_e.alu_control;
    assign jalrE       = ctrl_e.jalr;
    assign MemWriteM   = mem_write_m;
    assign RegWriteW   = reg_write_w;
    assign ResultSrcW  = result_src_w;
    assign clear       = 1'b0;

    pipeline_hazard_unit hazard (
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RdM        (RdM),
        .RdW        (RdW),
        .RegWriteM  (reg_write_m),
        .RegWriteW  (reg_write_w),
        .ResultSrcE (ctrl_e.result_src),
        .PCSrcE     (PCSrcE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE)
    );
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: scripted instruction streams with a register-number pipeline model;
// expected control values are queued at issue time and compared when the instruction reaches its stage.
module tb_pipeline_controller;
    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] B = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, LUI = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0, reset = 1'b1;
    logic [6:0] opcode = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       ZeroE = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
    logic [2:0] ImmSrcD, ALUControlE;
    logic       ALUSrcE, jalrE, PCSrcE, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcW, ForwardAE, ForwardBE;
    logic       StallF, StallD, FlushD, FlushE, clear;

    pipeline_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7), .ZeroE(ZeroE),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .jalrE(jalrE),
        .PCSrcE(PCSrcE), .MemWriteM(MemWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .clear(clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cyc;
        string tag;
        int    val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0, checks = 0, failures = 0;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int obs(input string tag);
        case (tag)
            "ImmSrcD":     return int'(ImmSrcD);
            "ALUSrcE":     return int'(ALUSrcE);
            "ALUControlE": return int'(ALUControlE);
            "jalrE":       return int'(jalrE);
            "PCSrcE":      return int'(PCSrcE);
            "MemWriteM":   return int'(MemWriteM);
            "RegWriteW":   return int'(RegWriteW);
            "ResultSrcW":  return int'(ResultSrcW);
            "ForwardAE":   return int'(ForwardAE);
            "ForwardBE":   return int'(ForwardBE);
            "StallF":      return int'(StallF);
            "StallD":      return int'(StallD);
            "FlushD":      return int'(FlushD);
            "FlushE":      return int'(FlushE);
            default:       return -1;
        endcase
    endfunction

    task automatic push_exp(input int dc, input string tag, input int val);
        q.push_back('{cyc + dc, tag, val});
    endtask

    // One cycle with the given instruction in D; ZeroE belongs to whatever sits in E this cycle.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input logic z);
        logic fe;
        int   i;
        opcode = op; funct3 = f3; funct7 = f7; Rs1D = rs1; Rs2D = rs2; ZeroE = z;
        @(negedge clk);
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                check(q[i].tag, obs(q[i].tag), q[i].val);
                q.delete(i);
            end else i++;
        end
        fe = FlushE;
        @(posedge clk);
        #1;
        RdW = RdM;
        RdM = RdE;
        {Rs1E, Rs2E, RdE} = fe ? 15'd0 : {rs1, rs2, rd};
        cyc++;
    endtask

    task automatic nop(input logic z);
        step(I, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, z);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_PCSrcE", int'(PCSrcE), 0);
        check("rst_RegWriteW", int'(RegWriteW), 0);
        check("rst_FlushE", int'(FlushE), 0);
        reset = 1'b0;
        repeat (3) nop(1'b0);

        // add x5,x1,x2 ; sub x6,x5,x3 -> M-stage forward
        push_exp(1, "ALUControlE", 0); push_exp(2, "ForwardAE", 2); push_exp(2, "ForwardBE", 0);
        push_exp(3, "RegWriteW", 1); push_exp(3, "ResultSrcW", 0);
        step(R, 3'b000, 7'h00, 5'd5, 5'd1, 5'd2, 1'b0);
        push_exp(1, "ALUControlE", 1);
        step(R, 3'b000, 7'h20, 5'd6, 5'd5, 5'd3, 1'b0);
        nop(1'b0);
        // add ; nop ; sub -> W-stage forward
        push_exp(3, "ForwardAE", 1);
        step(R, 3'b000, 7'h00, 5'd5, 5'd1, 5'd2, 1'b0);
        nop(1'b0);
        step(R, 3'b000, 7'h20, 5'd6, 5'd5, 5'd3, 1'b0);
        repeat (3) nop(1'b0);

        // lw x5,0(x1) ; add x6,x5,x0 -> one stall cycle then W forward
        push_exp(1, "StallF", 1); push_exp(1, "StallD", 1); push_exp(1, "FlushE", 1);
        push_exp(2, "StallF", 0); push_exp(2, "FlushE", 0);
        push_exp(3, "ForwardAE", 1); push_exp(3, "ForwardBE", 0);
        push_exp(3, "RegWriteW", 1); push_exp(3, "ResultSrcW", 1);
        step(LW, 3'b010, 7'd0, 5'd5, 5'd1, 5'd0, 1'b0);
        step(R, 3'b000, 7'd0, 5'd6, 5'd5, 5'd0, 1'b0);
        step(R, 3'b000, 7'd0, 5'd6, 5'd5, 5'd0, 1'b0);
        repeat (3) nop(1'b0);

        // branches
        push_exp(0, "ImmSrcD", 2); push_exp(1, "PCSrcE", 1); push_exp(1, "FlushD", 1);
        push_exp(1, "FlushE", 1); push_exp(1, "ALUControlE", 1); push_exp(2, "PCSrcE", 0);
        step(B, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b1);
        nop(1'b1);
        push_exp(1, "PCSrcE", 0); push_exp(1, "FlushD", 0);
        step(B, 3'b001, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b1);
        push_exp(1, "PCSrcE", 1); push_exp(1, "ALUControlE", 4);
        step(B, 3'b100, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b0);
        nop(1'b0);
        push_exp(1, "PCSrcE", 0);
        step(B, 3'b101, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b0);
        push_exp(1, "PCSrcE", 1);
        step(B, 3'b101, 7'd0, 5'd0, 5'd1, 5'd2, 1'b0);
        nop(1'b1);
        nop(1'b0);

        // jalr x1,8(x2) and jal x3
        push_exp(0, "ImmSrcD", 0); push_exp(1, "jalrE", 1); push_exp(1, "PCSrcE", 1);
        push_exp(1, "ALUSrcE", 1); push_exp(3, "RegWriteW", 1); push_exp(3, "ResultSrcW", 2);
        step(JALR, 3'b000, 7'd0, 5'd1, 5'd2, 5'd8, 1'b0);
        repeat (3) nop(1'b0);
        push_exp(0, "ImmSrcD", 3); push_exp(1, "PCSrcE", 1); push_exp(1, "jalrE", 0);
        step(JAL, 3'b000, 7'd0, 5'd3, 5'd0, 5'd0, 1'b0);
        repeat (2) nop(1'b0);

        // x0 is never forwarded; lui and sw
        push_exp(2, "ForwardAE", 0); push_exp(2, "ForwardBE", 0);
        step(I, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 1'b0);
        step(R, 3'b000, 7'd0, 5'd8, 5'd0, 5'd0, 1'b0);
        push_exp(0, "ImmSrcD", 4); push_exp(3, "ResultSrcW", 3); push_exp(3, "RegWriteW", 1);
        step(LUI, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 1'b0);
        push_exp(0, "ImmSrcD", 1); push_exp(1, "ALUSrcE", 1); push_exp(2, "MemWriteM", 1);
        step(SW, 3'b010, 7'd0, 5'd4, 5'd1, 5'd5, 1'b0);
        nop(1'b0);

        // ALU op decode corners
        push_exp(1, "ALUControlE", 2); push_exp(1, "ALUSrcE", 1);
        step(I, 3'b111, 7'd0, 5'd9, 5'd1, 5'd3, 1'b0);
        push_exp(1, "ALUControlE", 5); push_exp(1, "ALUSrcE", 0);
        step(R, 3'b100, 7'd0, 5'd9, 5'd1, 5'd3, 1'b0);
        push_exp(1, "ALUControlE", 6);
        step(R, 3'b011, 7'd0, 5'd9, 5'd1, 5'd3, 1'b0);
        push_exp(1, "ALUControlE", 3);
        step(R, 3'b110, 7'h20, 5'd9, 5'd1, 5'd3, 1'b0);
        push_exp(1, "ALUControlE", 0);
        step(I, 3'b000, 7'h7f, 5'd9, 5'd1, 5'd3, 1'b0);
        push_exp(1, "ALUControlE", 4);
        step(I, 3'b010, 7'd0, 5'd9, 5'd1, 5'd3, 1'b0);
        repeat (3) nop(1'b0);

        // unknown opcode behaves as a NOP
        push_exp(0, "ImmSrcD", 0); push_exp(1, "StallF", 0); push_exp(1, "ALUSrcE", 0);
        push_exp(2, "ForwardAE", 0); push_exp(3, "RegWriteW", 0);
        step(BAD, 3'b010, 7'd0, 5'd5, 5'd1, 5'd2, 1'b0);
        step(R, 3'b000, 7'd0, 5'd6, 5'd5, 5'd0, 1'b0);
        repeat (3) nop(1'b0);

        // reset mid-stream: jal in E, sw in M, lui in W
        step(LUI, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 1'b0);
        step(SW, 3'b010, 7'd0, 5'd4, 5'd7, 5'd7, 1'b0);
        step(JAL, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 1'b0);
        opcode = LW; funct3 = 3'b010; Rs1D = RdE; Rs2D = RdE;
        check("pre_rst_PCSrcE", int'(PCSrcE), 1);
        check("pre_rst_MemWriteM", int'(MemWriteM), 1);
        check("pre_rst_RegWriteW", int'(RegWriteW), 1);
        #2 reset = 1'b1;
        #1;
        q.delete();
        check("rst_PCSrcE_async", int'(PCSrcE), 0);
        check("rst_MemWriteM_async", int'(MemWriteM), 0);
        check("rst_RegWriteW_async", int'(RegWriteW), 0);
        check("rst_ResultSrcW", int'(ResultSrcW), 0);
        check("rst_jalrE", int'(jalrE), 0);
        check("rst_ALUSrcE", int'(ALUSrcE), 0);
        check("rst_ALUControlE", int'(ALUControlE), 0);
        check("rst_ForwardAE", int'(ForwardAE), 0);
        check("rst_ForwardBE", int'(ForwardBE), 0);
        check("rst_StallF", int'(StallF), 0);
        check("rst_StallD", int'(StallD), 0);
        check("rst_FlushD", int'(FlushD), 0);
        check("rst_FlushE_async", int'(FlushE), 0);
        check("rst_ImmSrcD", int'(ImmSrcD), 0);
        check("rst_clear", int'(clear), 0);
        @(posedge clk);
        #1;
        check("rst_held_PCSrcE", int'(PCSrcE), 0);
        check("rst_held_StallF", int'(StallF), 0);
        check("rst_held_FlushE", int'(FlushE), 0);
        check("rst_held_RegWriteW", int'(RegWriteW), 0);
        reset = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;

        // pipeline resumes after reset
        push_exp(3, "ResultSrcW", 3); push_exp(3, "RegWriteW", 1);
        step(LUI, 3'b000, 7'd0, 5'd7, 5'd0, 5'd0, 1'b0);
        repeat (4) nop(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
